// File: rtl/mbus_tx_seq_pkg.sv
// Shared definitions for the MBus TX sequencer.
//
// Contents:
//   state_t             - sequencer FSM state encoding
//   ST_*                - completion STATUS codes reported with DONE
//   DEF_FIFO_DEPTH      - default data-word buffer depth
//   DEF_TIMEOUT_CYCLES  - default watchdog limit (used only when the
//                         MBUS_TX_SEQ_TIMEOUT_EN build option is defined)
package mbus_tx_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD    = 3'd1,
    S_REQ     = 3'd2,
    S_ACKLOW  = 3'd3,
    S_RESP    = 3'd4,
    S_RESPACK = 3'd5,
    S_DRAIN   = 3'd6,
    S_FIN     = 3'd7
  } state_t;

  localparam logic [1:0] ST_OK      = 2'b00;
  localparam logic [1:0] ST_BUSFAIL = 2'b01;
  localparam logic [1:0] ST_TIMEOUT = 2'b10;
  localparam logic [1:0] ST_LENERR  = 2'b11;

  localparam int DEF_FIFO_DEPTH     = 4;
  localparam int DEF_TIMEOUT_CYCLES = 65535;

endpackage

// File: rtl/mbus_tx_sequencer_if.sv
// Bundle of the command, data-word, MBus TX and completion signals of the
// MBus TX sequencer.
//
// Signals:
//   CMD_VALID/CMD_READY, CMD_ADDR[31:0], CMD_LEN[7:0], CMD_PRIORITY - command
//   WR_VALID/WR_READY, WR_DATA[31:0]                               - data words
//   TX_ADDR, TX_DATA[31:0], TX_REQ, TX_PEND, TX_PRIORITY           - to MBus
//   TX_ACK, TX_SUCC, TX_FAIL (async), TX_RESP_ACK                  - MBus handshake
//   DONE, STATUS[1:0]                                              - completion
// Modports:
//   master - the sequencer
//   slave  - the command source / MBus side
interface mbus_tx_sequencer_if;

  logic        CMD_VALID;
  logic        CMD_READY;
  logic [31:0] CMD_ADDR;
  logic [7:0]  CMD_LEN;
  logic        CMD_PRIORITY;

  logic        WR_VALID;
  logic        WR_READY;
  logic [31:0] WR_DATA;

  logic [31:0] TX_ADDR;
  logic [31:0] TX_DATA;
  logic        TX_REQ;
  logic        TX_PEND;
  logic        TX_PRIORITY;
  logic        TX_ACK;
  logic        TX_SUCC;
  logic        TX_FAIL;
  logic        TX_RESP_ACK;

  logic        DONE;
  logic [1:0]  STATUS;

  modport master (
    input  CMD_VALID, CMD_ADDR, CMD_LEN, CMD_PRIORITY,
    input  WR_VALID, WR_DATA,
    input  TX_ACK, TX_SUCC, TX_FAIL,
    output CMD_READY, WR_READY,
    output TX_ADDR, TX_DATA, TX_REQ, TX_PEND, TX_PRIORITY, TX_RESP_ACK,
    output DONE, STATUS
  );

  modport slave (
    output CMD_VALID, CMD_ADDR, CMD_LEN, CMD_PRIORITY,
    output WR_VALID, WR_DATA,
    output TX_ACK, TX_SUCC, TX_FAIL,
    input  CMD_READY, WR_READY,
    input  TX_ADDR, TX_DATA, TX_REQ, TX_PEND, TX_PRIORITY, TX_RESP_ACK,
    input  DONE, STATUS
  );

endinterface

// File: rtl/mbus_tx_word_fifo.sv
// Synchronous data-word FIFO for the MBus TX sequencer.
// Show-ahead read: o_rdata is the head word whenever o_empty is 0.
// Pointers carry one extra wrap bit; full/empty come from the MSB compare.
//
// Ports:
//   i_clk, i_rst_n        - clock, asynchronous active-low reset
//   i_push, i_wdata       - write a word (ignored when full or flushing)
//   i_pop                 - drop the head word (ignored when empty)
//   i_flush               - discard all contents
//   o_rdata               - head word
//   o_full, o_empty       - occupancy flags
module mbus_tx_word_fifo #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_push,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic              i_pop,
  input  logic              i_flush,
  output logic [DATA_W-1:0] o_rdata,
  output logic              o_full,
  output logic              o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]       r_wr_ptr;
  logic [AW:0]       r_rd_ptr;
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic              w_do_push;
  logic              w_do_pop;

  assign o_empty   = (r_wr_ptr == r_rd_ptr);
  assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_do_push = i_push && !o_full && !i_flush;
  assign w_do_pop  = i_pop && !o_empty;
  assign o_rdata   = r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // Storage carries no reset; only the pointers define validity.
  always_ff @(posedge i_clk) begin
    if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_wdata;
  end

endmodule

// File: rtl/mbus_tx_sequencer.sv
// MBus TX sequencer: feeds one message (address, word stream, priority) to
// the MBus general-layer TX port, runs the TX_REQ/TX_ACK four-phase handshake
// per word and the TX_SUCC/TX_FAIL/TX_RESP_ACK response handshake, and reports
// one STATUS per message with a DONE pulse.
//
// Ports:
//   CLK     - system clock
//   RESETn  - asynchronous active-low reset
//   bus     - mbus_tx_sequencer_if.master (command, data words, MBus TX,
//             completion)
// Parameters:
//   FIFO_DEPTH     - data-word buffer depth (power of two, 2..16)
//   TIMEOUT_CYCLES - watchdog limit in CLK cycles (max 2^20-1)
// Build option:
//   MBUS_TX_SEQ_TIMEOUT_EN - when defined, a watchdog aborts a message with
//   STATUS=10 after TIMEOUT_CYCLES cycles in one waiting state. Otherwise the
//   FSM waits indefinitely.
module mbus_tx_sequencer
  import mbus_tx_seq_pkg::*;
#(
  parameter int FIFO_DEPTH     = DEF_FIFO_DEPTH,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                 CLK,
  input  logic                 RESETn,
  mbus_tx_sequencer_if.master  bus
);

  state_t      r_state;
  state_t      w_state_nxt;
  logic        r_cmd_ready;
  logic        r_tx_req;
  logic        r_resp_ack;
  logic        r_done;
  logic [1:0]  r_status;
  logic [1:0]  r_code;
  logic [1:0]  w_code_nxt;
  logic [31:0] r_addr;
  logic        r_prio;
  logic [31:0] r_tx_data;
  logic        r_tx_pend;
  logic [7:0]  r_rem;
  logic [7:0]  r_wr_left;

  logic [1:0]  r_ack_sync;
  logic [1:0]  r_succ_sync;
  logic [1:0]  r_fail_sync;
  logic        w_ack;
  logic        w_succ;
  logic        w_fail;

  logic        w_cmd_acc;
  logic        w_wr_ready;
  logic        w_wr_fire;
  logic        w_push;
  logic        w_pop;
  logic        w_flush;
  logic [31:0] w_fifo_rdata;
  logic        w_fifo_full;
  logic        w_fifo_empty;
  logic        w_wdog_hit;

  // ---- Input synchronizers: MBus response lines are asynchronous to CLK ----
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      r_ack_sync  <= '0;
      r_succ_sync <= '0;
      r_fail_sync <= '0;
    end else begin
      r_ack_sync  <= {r_ack_sync[0],  bus.TX_ACK};
      r_succ_sync <= {r_succ_sync[0], bus.TX_SUCC};
      r_fail_sync <= {r_fail_sync[0], bus.TX_FAIL};
    end
  end

  assign w_ack  = r_ack_sync[1];
  assign w_succ = r_succ_sync[1];
  assign w_fail = r_fail_sync[1];

  // r_cmd_ready is high exactly in IDLE, except the first cycle after reset.
  assign w_cmd_acc  = r_cmd_ready && bus.CMD_VALID;
  assign w_wr_ready = (r_state != S_IDLE) && (r_state != S_FIN) &&
                      (!w_fifo_full || (r_state == S_DRAIN));
  assign w_wr_fire  = bus.WR_VALID && w_wr_ready;
  // Words accepted while draining are counted but discarded.
  assign w_push     = w_wr_fire && (r_state != S_DRAIN);

  mbus_tx_word_fifo #(
    .DEPTH  (FIFO_DEPTH),
    .DATA_W (32)
  ) u_fifo (
    .i_clk   (CLK),
    .i_rst_n (RESETn),
    .i_push  (w_push),
    .i_wdata (bus.WR_DATA),
    .i_pop   (w_pop),
    .i_flush (w_flush),
    .o_rdata (w_fifo_rdata),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty)
  );

`ifdef MBUS_TX_SEQ_TIMEOUT_EN
  localparam logic [19:0] TO_LAST = 20'(TIMEOUT_CYCLES - 1);

  logic [19:0] r_wdog;
  logic        w_wdog_cnt;

  assign w_wdog_cnt = (r_state == S_LOAD) || (r_state == S_REQ) ||
                      (r_state == S_ACKLOW) || (r_state == S_RESP) ||
                      (r_state == S_RESPACK);
  // r_wdog is 0 in the first cycle of a state, so the hit lands exactly
  // TIMEOUT_CYCLES cycles after entry.
  assign w_wdog_hit = w_wdog_cnt && (r_wdog == TO_LAST);

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn)                    r_wdog <= '0;
    else if (w_state_nxt != r_state) r_wdog <= '0;
    else if (w_wdog_cnt)             r_wdog <= r_wdog + 20'd1;
  end
`else
  logic [19:0] w_unused_to;
  assign w_unused_to = 20'(TIMEOUT_CYCLES);
  assign w_wdog_hit  = 1'b0;
`endif

  // ---- Next-state logic ----
  always_comb begin
    w_state_nxt = r_state;
    w_code_nxt  = r_code;
    w_pop       = 1'b0;
    w_flush     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_cmd_acc) begin
          if (bus.CMD_LEN == 8'd0) begin
            w_state_nxt = S_FIN;
            w_code_nxt  = ST_LENERR;
          end else begin
            w_state_nxt = S_LOAD;
            w_code_nxt  = ST_OK;
          end
        end
      end
      S_LOAD: begin
        if (w_fail) begin
          w_state_nxt = S_RESPACK;
          w_code_nxt  = ST_BUSFAIL;
        end else if (!w_fifo_empty) begin
          w_pop       = 1'b1;
          w_state_nxt = S_REQ;
        end
      end
      S_REQ: begin
        if (w_fail) begin
          w_state_nxt = S_RESPACK;
          w_code_nxt  = ST_BUSFAIL;
        end else if (w_ack) begin
          w_state_nxt = S_ACKLOW;
        end
      end
      S_ACKLOW: begin
        if (w_fail) begin
          w_state_nxt = S_RESPACK;
          w_code_nxt  = ST_BUSFAIL;
        end else if (!w_ack) begin
          w_state_nxt = (r_rem != 8'd0) ? S_LOAD : S_RESP;
        end
      end
      S_RESP: begin
        if (w_fail) begin
          w_state_nxt = S_RESPACK;
          w_code_nxt  = ST_BUSFAIL;
        end else if (w_succ) begin
          w_state_nxt = S_RESPACK;
          w_code_nxt  = ST_OK;
        end
      end
      S_RESPACK: begin
        if (!w_succ && !w_fail) begin
          if (r_code == ST_BUSFAIL) begin
            // Leftover words of the failed message must not leak into the
            // next one; the rest still arriving on WR is drained.
            w_flush     = 1'b1;
            w_state_nxt = S_DRAIN;
          end else begin
            w_state_nxt = S_FIN;
          end
        end
      end
      S_DRAIN: begin
        if (r_wr_left == 8'd0) w_state_nxt = S_FIN;
      end
      S_FIN: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
    if (w_wdog_hit) begin
      w_state_nxt = S_FIN;
      w_code_nxt  = ST_TIMEOUT;
      w_pop       = 1'b0;
      w_flush     = 1'b1;
    end
  end

  // ---- State and registered outputs ----
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      r_state     <= S_IDLE;
      r_cmd_ready <= 1'b0;
      r_tx_req    <= 1'b0;
      r_resp_ack  <= 1'b0;
      r_done      <= 1'b0;
      r_status    <= ST_OK;
      r_code      <= ST_OK;
      r_addr      <= '0;
      r_prio      <= 1'b0;
      r_tx_data   <= '0;
      r_tx_pend   <= 1'b0;
      r_rem       <= '0;
      r_wr_left   <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_cmd_ready <= (w_state_nxt == S_IDLE);
      r_tx_req    <= (w_state_nxt == S_REQ);
      r_resp_ack  <= (w_state_nxt == S_RESPACK);
      r_done      <= (w_state_nxt == S_FIN);
      r_code      <= w_code_nxt;
      if ((w_state_nxt == S_FIN) && (r_state != S_FIN)) r_status <= w_code_nxt;
      if (w_cmd_acc) begin
        r_addr <= bus.CMD_ADDR;
        r_prio <= bus.CMD_PRIORITY;
        r_rem  <= bus.CMD_LEN;
      end
      if (w_pop) begin
        r_tx_data <= w_fifo_rdata;
        r_tx_pend <= (r_rem > 8'd1);
        r_rem     <= r_rem - 8'd1;
      end
      // Words of this message not yet accepted on WR; drives the drain.
      if (w_cmd_acc)                           r_wr_left <= bus.CMD_LEN;
      else if (w_wr_fire && (r_wr_left != 8'd0)) r_wr_left <= r_wr_left - 8'd1;
    end
  end

  assign bus.CMD_READY   = r_cmd_ready;
  assign bus.WR_READY    = w_wr_ready;
  assign bus.TX_ADDR     = r_addr;
  assign bus.TX_DATA     = r_tx_data;
  assign bus.TX_REQ      = r_tx_req;
  assign bus.TX_PEND     = r_tx_pend;
  assign bus.TX_PRIORITY = r_prio;
  assign bus.TX_RESP_ACK = r_resp_ack;
  assign bus.DONE        = r_done;
  assign bus.STATUS      = r_status;

endmodule

// File: tb/tb_mbus_tx_sequencer.sv
// Directed bench for mbus_tx_sequencer: single word, three words, bus fail,
// fail with drain, zero length, optional watchdog, and reset mid-message.
module tb_mbus_tx_sequencer;

  logic CLK    = 1'b0;
  logic RESETn = 1'b0;
  int   n_assert  = 0;
  int   n_fail    = 0;
  int   req_rises = 0;
  int   req_base  = 0;

  mbus_tx_sequencer_if bus();

  mbus_tx_sequencer #(
    .FIFO_DEPTH     (4),
    .TIMEOUT_CYCLES (100)
  ) u_dut (
    .CLK    (CLK),
    .RESETn (RESETn),
    .bus    (bus)
  );

  always #5 CLK = ~CLK;

  always @(posedge bus.TX_REQ) req_rises++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic sig_val(input int sel);
    case (sel)
      0:       return bus.TX_REQ;
      1:       return bus.TX_RESP_ACK;
      2:       return bus.DONE;
      3:       return bus.CMD_READY;
      default: return bus.WR_READY;
    endcase
  endfunction

  // Bounded wait at negedges; an expired budget shows up as a failed check.
  task automatic wait_sig(input int sel, input logic val, input string tag);
    int n = 0;
    while (sig_val(sel) !== val && n < 500) begin
      @(negedge CLK);
      n++;
    end
    check({tag, "_wait"}, 32'(sig_val(sel)), 32'(val));
  endtask

  task automatic send_cmd(input logic [31:0] addr, input logic [7:0] len, input logic prio);
    bus.CMD_VALID    = 1'b1;
    bus.CMD_ADDR     = addr;
    bus.CMD_LEN      = len;
    bus.CMD_PRIORITY = prio;
    wait_sig(3, 1'b1, "cmd_ready");
    @(negedge CLK);
    bus.CMD_VALID = 1'b0;
  endtask

  task automatic push_word(input logic [31:0] d);
    bus.WR_VALID = 1'b1;
    bus.WR_DATA  = d;
    wait_sig(4, 1'b1, "wr_ready");
    @(negedge CLK);
    bus.WR_VALID = 1'b0;
  endtask

  task automatic bus_ack(input logic [31:0] d, input logic pend, input string tag);
    int n = 0;
    wait_sig(0, 1'b1, {tag, "_req"});
    check({tag, "_data"}, bus.TX_DATA, d);
    check({tag, "_pend"}, 32'(bus.TX_PEND), 32'(pend));
    bus.TX_ACK = 1'b1;
    while (bus.TX_REQ === 1'b1 && n < 50) begin
      @(negedge CLK);
      n++;
    end
    check({tag, "_ack_lat"}, 32'(n), 32'd3);
    bus.TX_ACK = 1'b0;
  endtask

  task automatic bus_resp(input logic fail, input string tag);
    if (fail) bus.TX_FAIL = 1'b1;
    else      bus.TX_SUCC = 1'b1;
    wait_sig(1, 1'b1, {tag, "_rack"});
    bus.TX_FAIL = 1'b0;
    bus.TX_SUCC = 1'b0;
    wait_sig(1, 1'b0, {tag, "_rack_drop"});
  endtask

  task automatic expect_done(input logic [1:0] st, input string tag);
    wait_sig(2, 1'b1, {tag, "_done"});
    check({tag, "_status"}, 32'(bus.STATUS), 32'(st));
    @(negedge CLK);
    check({tag, "_done_pulse"}, 32'(bus.DONE), 32'd0);
  endtask

  initial begin
    bus.CMD_VALID = 1'b0; bus.CMD_ADDR = '0; bus.CMD_LEN = '0; bus.CMD_PRIORITY = 1'b0;
    bus.WR_VALID = 1'b0;  bus.WR_DATA = '0;
    bus.TX_ACK = 1'b0;    bus.TX_SUCC = 1'b0;  bus.TX_FAIL = 1'b0;

    // Reset values
    repeat (3) @(negedge CLK);
    check("rst_cmd_ready", 32'(bus.CMD_READY), 32'd0);
    check("rst_tx_req", 32'(bus.TX_REQ), 32'd0);
    check("rst_wr_ready", 32'(bus.WR_READY), 32'd0);
    check("rst_done", 32'(bus.DONE), 32'd0);
    check("rst_status", 32'(bus.STATUS), 32'd0);
    check("rst_tx_data", bus.TX_DATA, 32'd0);
    RESETn = 1'b1;
    @(negedge CLK);
    check("rel_cmd_ready", 32'(bus.CMD_READY), 32'd1);

    // Single word
    send_cmd(32'hADDAADDA, 8'd1, 1'b1);
    check("t1_cmd_ready_low", 32'(bus.CMD_READY), 32'd0);
    check("t1_tx_addr", bus.TX_ADDR, 32'hADDAADDA);
    check("t1_tx_prio", 32'(bus.TX_PRIORITY), 32'd1);
    push_word(32'hDADADADA);
    bus_ack(32'hDADADADA, 1'b0, "t1_w0");
    bus_resp(1'b0, "t1");
    expect_done(2'b00, "t1");
    check("t1_addr_hold", bus.TX_ADDR, 32'hADDAADDA);

    // Three words
    req_base = req_rises;
    send_cmd(32'h0000_0003, 8'd3, 1'b0);
    check("t2_tx_prio", 32'(bus.TX_PRIORITY), 32'd0);
    push_word(32'h11111111);
    push_word(32'h22222222);
    push_word(32'h33333333);
    bus_ack(32'h11111111, 1'b1, "t2_w0");
    bus_ack(32'h22222222, 1'b1, "t2_w1");
    bus_ack(32'h33333333, 1'b0, "t2_w2");
    bus_resp(1'b0, "t2");
    expect_done(2'b00, "t2");
    check("t2_req_count", 32'(req_rises - req_base), 32'd3);

    // ACK then TX_FAIL response
    send_cmd(32'hCAFE0001, 8'd1, 1'b0);
    push_word(32'hBEEF0001);
    bus_ack(32'hBEEF0001, 1'b0, "t3_w0");
    bus_resp(1'b1, "t3");
    expect_done(2'b01, "t3");
    repeat (3) @(negedge CLK);
    check("t3_status_hold", 32'(bus.STATUS), 32'd1);

    // TX_FAIL during word 2 of LEN=4, remaining words drained
    req_base = req_rises;
    send_cmd(32'hCAFE0004, 8'd4, 1'b0);
    push_word(32'hA0000001);
    push_word(32'hA0000002);
    bus_ack(32'hA0000001, 1'b1, "t4_w0");
    wait_sig(0, 1'b1, "t4_w1_req");
    check("t4_w1_data", bus.TX_DATA, 32'hA0000002);
    bus.TX_FAIL = 1'b1;
    wait_sig(1, 1'b1, "t4_rack");
    check("t4_req_dropped", 32'(bus.TX_REQ), 32'd0);
    bus.TX_FAIL = 1'b0;
    wait_sig(1, 1'b0, "t4_rack_drop");
    check("t4_drain_wr_ready", 32'(bus.WR_READY), 32'd1);
    push_word(32'hA0000003);
    push_word(32'hA0000004);
    expect_done(2'b01, "t4");
    check("t4_req_count", 32'(req_rises - req_base), 32'd2);

    // LEN=0: length error, no bus activity
    req_base = req_rises;
    send_cmd(32'h00000000, 8'd0, 1'b0);
    check("t5_done", 32'(bus.DONE), 32'd1);
    check("t5_status", 32'(bus.STATUS), 32'd3);
    check("t5_wr_ready", 32'(bus.WR_READY), 32'd0);
    @(negedge CLK);
    check("t5_done_pulse", 32'(bus.DONE), 32'd0);
    check("t5_req_count", 32'(req_rises - req_base), 32'd0);

`ifdef MBUS_TX_SEQ_TIMEOUT_EN
    // Watchdog: TX_ACK never comes
    begin
      int n = 0;
      send_cmd(32'h7100_0001, 8'd1, 1'b0);
      push_word(32'h7100DA7A);
      wait_sig(0, 1'b1, "t6_req");
      while (bus.DONE !== 1'b1 && n < 300) begin
        @(negedge CLK);
        n++;
      end
      check("t6_timeout_cycles", 32'(n), 32'd100);
      check("t6_status", 32'(bus.STATUS), 32'd2);
      check("t6_req_low", 32'(bus.TX_REQ), 32'd0);
      @(negedge CLK);
    end
`endif

    // Reset in REQ of a 2-word message
    send_cmd(32'h0BAD0002, 8'd2, 1'b1);
    push_word(32'hA1A1A1A1);
    push_word(32'hA2A2A2A2);
    wait_sig(0, 1'b1, "t7_req");
    check("t7_data", bus.TX_DATA, 32'hA1A1A1A1);
    RESETn = 1'b0;
    #1;
    check("t7_async_req", 32'(bus.TX_REQ), 32'd0);
    check("t7_async_cmd_ready", 32'(bus.CMD_READY), 32'd0);
    check("t7_async_data", bus.TX_DATA, 32'd0);
    check("t7_async_prio", 32'(bus.TX_PRIORITY), 32'd0);
    @(negedge CLK);
    @(negedge CLK);
    RESETn = 1'b1;
    @(negedge CLK);
    check("t7_cmd_ready", 32'(bus.CMD_READY), 32'd1);
    send_cmd(32'h12345678, 8'd1, 1'b0);
    push_word(32'h5A5A5A5A);
    bus_ack(32'h5A5A5A5A, 1'b0, "t7_new");
    bus_resp(1'b0, "t7");
    expect_done(2'b00, "t7");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: observed no end of test, required end before 1 ms");
    $fatal(1, "simulation time limit");
  end

endmodule
